// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-multiplexed FIR filter built around one signed MAC.
// For each accepted sample it walks NTAPS taps, then rounds, rescales by
// 2^-SHIFT and saturates the sum to AW bits. Coefficients are writable in IDLE.
module fir_mac_sequencer #(
   parameter int unsigned NTAPS = 7,
   parameter int unsigned DW    = 8,
   parameter int unsigned CW    = 8,
   parameter int unsigned ACCW  = 20,
   parameter int unsigned SHIFT = 6,
   parameter int unsigned AW    = 8,
   localparam int unsigned KW   = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] in_data,
   output logic                 in_ready,
   input  logic                 coef_we,
   input  logic [KW-1:0]        coef_addr,
   input  logic signed [CW-1:0] coef_data,
   output logic                 coef_err,
   output logic                 out_valid,
   output logic signed [AW-1:0] out_data,
   input  logic                 out_ready,
   output logic                 out_sat,
   output logic                 busy
);

   localparam int unsigned PW       = DW + CW;
   localparam int unsigned C_CENTER = (NTAPS - 1) / 2;
   localparam logic [KW-1:0] C_LAST = KW'(NTAPS - 1);
   localparam logic signed [ACCW:0] C_HALF = (ACCW+1)'(64'(1) << (SHIFT - 1));
   localparam logic signed [ACCW:0] C_MAX  = (ACCW+1)'((64'(1) << (AW - 1)) - 64'(1));
   localparam logic signed [ACCW:0] C_MIN  = ~C_MAX;
   localparam logic signed [CW-1:0] C_UNITY = CW'(64'(1) << SHIFT);

   // RND is a one-cycle rounding stage between the last MAC and the output
   // register, so the result presents NTAPS+1 edges after acceptance.
   typedef enum logic [1:0] {S_IDLE, S_MAC, S_RND, S_OUT} state_t;

   state_t                r_state;
   logic signed [DW-1:0]  r_buf  [NTAPS];
   logic signed [CW-1:0]  r_coef [NTAPS];
   logic [KW-1:0]         r_wr_ptr;
   logic [KW-1:0]         r_newest;
   logic [KW-1:0]         r_k;
   logic signed [ACCW-1:0] r_acc;
   logic                  r_in_ready;
   logic                  r_coef_err;
   logic                  r_out_valid;
   logic signed [AW-1:0]  r_out_data;
   logic                  r_out_sat;
   logic                  r_busy;

   logic [KW-1:0]         w_rd_idx;
   logic signed [PW-1:0]  w_prod;
   logic signed [ACCW:0]  w_rnd_sum;
   logic signed [ACCW:0]  w_r;
   logic signed [AW-1:0]  w_sat_data;
   logic                  w_sat;
   logic                  w_addr_ok;

   // Circular read index: newest - k modulo NTAPS.
   always_comb begin
      w_rd_idx = r_newest - r_k;
      if (r_newest < r_k) begin
         w_rd_idx = KW'(r_newest + KW'(NTAPS) - r_k);
      end
   end

   assign w_prod    = r_buf[w_rd_idx] * r_coef[r_k];
   assign w_addr_ok = (32'(coef_addr) < NTAPS);

   // Round half up, arithmetic shift, then clip to the output range.
   assign w_rnd_sum = (ACCW+1)'(r_acc) + C_HALF;
   assign w_r       = w_rnd_sum >>> SHIFT;

   always_comb begin
      w_sat_data = AW'(w_r);
      w_sat      = 1'b0;
      if (w_r > C_MAX) begin
         w_sat_data = AW'(C_MAX);
         w_sat      = 1'b1;
      end else if (w_r < C_MIN) begin
         w_sat_data = AW'(C_MIN);
         w_sat      = 1'b1;
      end
   end

   // Sequencer FSM with sample buffer, coefficient file and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_wr_ptr    <= '0;
         r_newest    <= '0;
         r_k         <= '0;
         r_acc       <= '0;
         r_in_ready  <= 1'b1;
         r_coef_err  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sat   <= 1'b0;
         r_busy      <= 1'b0;
         for (int unsigned i = 0; i < NTAPS; i++) begin
            r_buf[KW'(i)]  <= '0;
            r_coef[KW'(i)] <= (i == C_CENTER) ? C_UNITY : '0;
         end
      end else begin
         r_coef_err <= 1'b0;
         if (coef_we) begin
            if ((r_state == S_IDLE) && w_addr_ok) begin
               r_coef[coef_addr] <= coef_data;
            end else begin
               r_coef_err <= 1'b1;
            end
         end

         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_buf[r_wr_ptr] <= in_data;
                  r_newest        <= r_wr_ptr;
                  r_wr_ptr        <= (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + 1'b1;
                  r_acc           <= '0;
                  r_k             <= '0;
                  r_in_ready      <= 1'b0;
                  r_busy          <= 1'b1;
                  r_state         <= S_MAC;
               end
            end
            S_MAC: begin
               r_acc <= r_acc + ACCW'(w_prod);
               if (r_k == C_LAST) begin
                  r_state <= S_RND;
               end else begin
                  r_k <= r_k + 1'b1;
               end
            end
            S_RND: begin
               r_out_data  <= w_sat_data;
               r_out_sat   <= w_sat;
               r_out_valid <= 1'b1;
               r_state     <= S_OUT;
            end
            S_OUT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign coef_err  = r_coef_err;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sat   = r_out_sat;
   assign busy      = r_busy;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: table-driven and scoreboard checks of fir_mac_sequencer.
module tb_fir_mac_sequencer;

   localparam int NTAPS = 7;
   localparam int SHIFT = 6;
   localparam int OMAX  = 127;
   localparam int OMIN  = -128;

   typedef struct {int x; int d; bit s;} vec_t;
   typedef struct {int d; bit s;} exp_t;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic signed [7:0] in_data;
   logic              in_ready;
   logic              coef_we;
   logic [2:0]        coef_addr;
   logic signed [7:0] coef_data;
   logic              coef_err;
   logic              out_valid;
   logic signed [7:0] out_data;
   logic              out_ready;
   logic              out_sat;
   logic              busy;

   exp_t q[$];
   int   checks  = 0;
   int   errors  = 0;
   int   cyc     = 0;
   int   acc_cyc = 0;
   int   m_hist[NTAPS];
   int   m_coef[NTAPS];

   fir_mac_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .out_sat(out_sat),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NTAPS; k++) begin
         m_hist[k] = 0;
         m_coef[k] = 0;
      end
      m_coef[(NTAPS-1)/2] = 1 << SHIFT;
      q.delete();
   endtask

   // Reference FIR: full sum, round half up, arithmetic shift, saturate.
   task automatic model_accept(input int x, output int d, output bit s);
      int sum;
      int r;
      for (int k = NTAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = x;
      sum = 0;
      for (int k = 0; k < NTAPS; k++) sum += m_coef[k] * m_hist[k];
      r = (sum + (1 << (SHIFT - 1))) >>> SHIFT;
      if (r > OMAX) begin d = OMAX; s = 1'b1; end
      else if (r < OMIN) begin d = OMIN; s = 1'b1; end
      else begin d = r; s = 1'b0; end
   endtask

   // Offer a sample until accepted; push the table or model expectation.
   task automatic accept(input int x, input bit use_tab, input int td, input bit ts, input bit push);
      int n;
      int md;
      bit ms;
      exp_t e;
      in_valid = 1'b1;
      in_data  = 8'(x);
      n = 0;
      while (!in_ready && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      chk("accept_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      acc_cyc  = cyc;
      model_accept(x, md, ms);
      if (push) begin
         e.d = use_tab ? td : md;
         e.s = use_tab ? ts : ms;
         q.push_back(e);
      end
   endtask

   // Wait for a result, check latency and value against the scoreboard.
   task automatic collect(input string nm, output int ed, output bit es);
      int   n;
      exp_t e;
      n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "_valid"}, out_valid, 1);
      chk({nm, "_lat"}, cyc - acc_cyc, NTAPS + 1);
      if (q.size() > 0) e = q.pop_front();
      else begin e.d = 0; e.s = 1'b0; end
      chk({nm, "_data"}, out_data, e.d);
      chk({nm, "_sat"}, out_sat, e.s);
      ed = e.d;
      es = e.s;
      if (out_ready) begin
         @(posedge clk); #1;
         chk({nm, "_drop"}, out_valid, 0);
         chk({nm, "_idle"}, in_ready, 1);
      end
   endtask

   task automatic write_coef(input int a, input int v, input bit exp_err, input string nm);
      coef_we   = 1'b1;
      coef_addr = 3'(a);
      coef_data = 8'(v);
      @(posedge clk); #1;
      coef_we = 1'b0;
      chk({nm, "_err"}, coef_err, exp_err);
      if (!exp_err) m_coef[a] = v;
      @(posedge clk); #1;
      chk({nm, "_err_clr"}, coef_err, 0);
   endtask

   task automatic run_table(input vec_t t[NTAPS], input string nm);
      int ed;
      bit es;
      for (int i = 0; i < NTAPS; i++) begin
         accept(t[i].x, 1'b1, t[i].d, t[i].s, 1'b1);
         collect($sformatf("%s_%0d", nm, i), ed, es);
      end
   endtask

   task automatic run_model(input int x, input int cnt, input string nm);
      int ed;
      bit es;
      for (int i = 0; i < cnt; i++) begin
         accept(x, 1'b0, 0, 1'b0, 1'b1);
         collect($sformatf("%s_%0d", nm, i), ed, es);
      end
   endtask

   initial begin
      vec_t t100[NTAPS];
      vec_t t64[NTAPS];
      int   h2[NTAPS];
      int   ed;
      bit   es;
      bit   seen;

      h2 = '{-2, 0, 34, 64, 34, 0, -2};
      for (int i = 0; i < NTAPS; i++) begin
         t100[i].x = (i == 0) ? 100 : 0;
         t100[i].d = (i == 3) ? 100 : 0;
         t100[i].s = 1'b0;
         t64[i].x  = (i == 0) ? 64 : 0;
         t64[i].d  = h2[i];
         t64[i].s  = 1'b0;
      end

      rst_n = 1'b1; in_valid = 1'b0; in_data = '0;
      coef_we = 1'b0; coef_addr = '0; coef_data = '0; out_ready = 1'b1;
      model_reset();
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_sat", out_sat, 0);
      chk("rst_busy", busy, 0);
      chk("rst_coef_err", coef_err, 0);

      // Default coefficients: unity-gain delay of three samples.
      run_table(t100, "imp100");

      // Symmetric low-pass load, impulse response exercises negative rounding.
      for (int k = 0; k < NTAPS; k++) write_coef(k, h2[k], 1'b0, $sformatf("load%0d", k));
      run_table(t64, "imp64");

      // Constant full-scale inputs drive both saturation rails.
      run_model(127, 8, "pos");
      chk("pos_steady_data", out_data, OMAX);
      chk("pos_steady_sat", out_sat, 1);
      run_model(-128, 8, "neg");
      chk("neg_steady_data", out_data, OMIN);
      chk("neg_steady_sat", out_sat, 1);

      // Back-pressure: result held, input refused, IDLE one cycle after release.
      out_ready = 1'b0;
      accept(90, 1'b0, 0, 1'b0, 1'b1);
      collect("hold", ed, es);
      for (int i = 0; i < 5; i++) begin
         in_valid = (i % 2 == 0);
         in_data  = 8'sd55;
         @(posedge clk); #1;
         chk($sformatf("hold_valid_%0d", i), out_valid, 1);
         chk($sformatf("hold_data_%0d", i), out_data, ed);
         chk($sformatf("hold_sat_%0d", i), out_sat, es);
         chk($sformatf("hold_in_ready_%0d", i), in_ready, 0);
         chk($sformatf("hold_busy_%0d", i), busy, 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("hold_release_valid", out_valid, 0);
      chk("hold_release_ready", in_ready, 1);
      chk("hold_release_busy", busy, 0);

      // Dropped writes: one during MAC, one with an out-of-range address.
      accept(0, 1'b0, 0, 1'b0, 1'b1);
      chk("mac_busy", busy, 1);
      write_coef(0, 99, 1'b1, "we_mac");
      collect("we_mac_out", ed, es);
      write_coef(7, 55, 1'b1, "addr7");
      run_model(0, NTAPS - 1, "flush");
      run_table(t64, "imp64_again");

      // Reset during MAC at k = 3: no output, defaults restored.
      accept(100, 1'b0, 0, 1'b0, 1'b0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         if (out_valid) seen = 1'b1;
         @(posedge clk); #1;
      end
      chk("rst_mac_no_out", seen, 0);
      chk("rst_mac_in_ready", in_ready, 1);
      chk("rst_mac_busy", busy, 0);
      run_table(t100, "imp100_after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
